// File: rtl/polygon_hit_tester.sv
// Even-odd point-in-polygon tester: streams one polygon edge per cycle from a
// vertex RAM through a three-stage crossing pipeline and reports parity/count.
module polygon_hit_tester #(
  parameter int unsigned WORLD_BITS = 32,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned MAX_VERTS  = 1024,
  parameter int unsigned CW         = $clog2(MAX_VERTS + 1)
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         query_valid_in,
  output logic                         query_ready_out,
  input  logic signed [WORLD_BITS-1:0] x_in,
  input  logic signed [WORLD_BITS-1:0] y_in,
  input  logic        [ADDR_BITS-1:0]  base_in,
  input  logic        [CW-1:0]         count_in,
  output logic                         vert_rd_out,
  output logic        [ADDR_BITS-1:0]  vert_addr_out,
  input  logic signed [WORLD_BITS-1:0] vert_x_in,
  input  logic signed [WORLD_BITS-1:0] vert_y_in,
  output logic                         result_valid_out,
  input  logic                         result_ready_in,
  output logic                         inside_out,
  output logic        [CW-1:0]         crossings_out,
  output logic                         degenerate_out
);

  localparam int unsigned W  = WORLD_BITS;
  localparam int unsigned DW = W + 1;
  localparam int unsigned PW = 2 * W + 2;
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                r_state;
  logic signed [W-1:0]   r_qx, r_qy;
  logic [ADDR_BITS-1:0]  r_base;
  logic [CW-1:0]         r_rem;
  logic [1:0]            r_drain;
  logic                  r_degen;
  logic                  r_parity;
  logic [CW-1:0]         r_cross;

  logic                  r_rd_d, r_have_prev;
  logic signed [W-1:0]   r_px, r_py;
  logic                  r_va, r_inb_a;
  logic signed [DW-1:0]  r_dxhl, r_dyp, r_dyhl, r_dxp;
  logic                  r_vb, r_inb_b;
  logic signed [PW-1:0]  r_p1, r_p2;

  logic                  w_accept;
  logic                  w_edge_v;
  logic signed [W-1:0]   w_hx, w_hy, w_lx, w_ly;
  logic                  w_inb;
  logic signed [DW-1:0]  w_hx_e, w_hy_e, w_lx_e, w_ly_e, w_qx_e, w_qy_e;
  logic signed [DW-1:0]  w_dxhl, w_dyp, w_dyhl, w_dxp;
  logic signed [PW-1:0]  w_dxhl_p, w_dyp_p, w_dyhl_p, w_dxp_p, w_p1, w_p2;
  logic signed [SW-1:0]  w_diff;
  logic                  w_cross;

  assign w_accept = query_ready_out && query_valid_in;
  // previous vertex (k) is held in r_px/r_py while vertex k+1 is on the bus
  assign w_edge_v = r_rd_d && r_have_prev;

  always_comb begin
    if (r_py > vert_y_in) begin
      w_hx = r_px;      w_hy = r_py;
      w_lx = vert_x_in; w_ly = vert_y_in;
    end else begin
      w_hx = vert_x_in; w_hy = vert_y_in;
      w_lx = r_px;      w_ly = r_py;
    end
  end

  assign w_inb  = (w_hy > r_qy) && (r_qy >= w_ly);
  assign w_hx_e = {w_hx[W-1], w_hx};
  assign w_hy_e = {w_hy[W-1], w_hy};
  assign w_lx_e = {w_lx[W-1], w_lx};
  assign w_ly_e = {w_ly[W-1], w_ly};
  assign w_qx_e = {r_qx[W-1], r_qx};
  assign w_qy_e = {r_qy[W-1], r_qy};
  assign w_dxhl = w_lx_e - w_hx_e;
  assign w_dyp  = w_qy_e - w_hy_e;
  assign w_dyhl = w_ly_e - w_hy_e;
  assign w_dxp  = w_qx_e - w_hx_e;

  assign w_dxhl_p = {{(PW-DW){r_dxhl[DW-1]}}, r_dxhl};
  assign w_dyp_p  = {{(PW-DW){r_dyp[DW-1]}},  r_dyp};
  assign w_dyhl_p = {{(PW-DW){r_dyhl[DW-1]}}, r_dyhl};
  assign w_dxp_p  = {{(PW-DW){r_dxp[DW-1]}},  r_dxp};
  assign w_p1     = w_dxhl_p * w_dyp_p;
  assign w_p2     = w_dyhl_p * w_dxp_p;

  assign w_diff  = {r_p1[PW-1], r_p1} - {r_p2[PW-1], r_p2};
  assign w_cross = r_vb && r_inb_b && (w_diff[SW-1] || (w_diff == '0));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_d      <= 1'b0;
      r_have_prev <= 1'b0;
      r_px        <= '0;
      r_py        <= '0;
      r_va        <= 1'b0;
      r_inb_a     <= 1'b0;
      r_dxhl      <= '0;
      r_dyp       <= '0;
      r_dyhl      <= '0;
      r_dxp       <= '0;
      r_vb        <= 1'b0;
      r_inb_b     <= 1'b0;
      r_p1        <= '0;
      r_p2        <= '0;
    end else begin
      r_rd_d <= vert_rd_out;
      if (w_accept) begin
        r_have_prev <= 1'b0;
      end else if (r_rd_d) begin
        r_have_prev <= 1'b1;
      end
      if (r_rd_d) begin
        r_px <= vert_x_in;
        r_py <= vert_y_in;
      end
      r_va    <= w_edge_v;
      r_inb_a <= w_inb;
      r_dxhl  <= w_dxhl;
      r_dyp   <= w_dyp;
      r_dyhl  <= w_dyhl;
      r_dxp   <= w_dxp;
      r_vb    <= r_va;
      r_inb_b <= r_inb_a;
      r_p1    <= w_p1;
      r_p2    <= w_p2;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state          <= IDLE;
      r_qx             <= '0;
      r_qy             <= '0;
      r_base           <= '0;
      r_rem            <= '0;
      r_drain          <= '0;
      r_degen          <= 1'b0;
      r_parity         <= 1'b0;
      r_cross          <= '0;
      query_ready_out  <= 1'b0;
      vert_rd_out      <= 1'b0;
      vert_addr_out    <= '0;
      result_valid_out <= 1'b0;
      inside_out       <= 1'b0;
      crossings_out    <= '0;
      degenerate_out   <= 1'b0;
    end else begin
      if (w_cross) begin
        r_cross  <= r_cross + CW'(1);
        r_parity <= ~r_parity;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            query_ready_out <= 1'b0;
            r_qx     <= x_in;
            r_qy     <= y_in;
            r_base   <= base_in;
            r_parity <= 1'b0;
            r_cross  <= '0;
            r_degen  <= (count_in < CW'(3));
            if (count_in < CW'(3)) begin
              // one DRAIN cycle keeps degenerate latency aligned at cycle 2
              r_state <= DRAIN;
              r_drain <= 2'd0;
            end else begin
              r_state       <= READ;
              vert_rd_out   <= 1'b1;
              vert_addr_out <= base_in;
              r_rem         <= count_in;
            end
          end else begin
            query_ready_out <= 1'b1;
          end
        end
        READ: begin
          if (r_rem == '0) begin
            vert_rd_out <= 1'b0;
            r_state     <= DRAIN;
            r_drain     <= 2'd3;
          end else begin
            r_rem         <= r_rem - CW'(1);
            vert_addr_out <= (r_rem == CW'(1)) ? r_base : vert_addr_out + ADDR_BITS'(1);
          end
        end
        DRAIN: begin
          if (r_drain == 2'd0) begin
            r_state          <= DONE;
            result_valid_out <= 1'b1;
            inside_out       <= r_parity;
            crossings_out    <= r_cross;
            degenerate_out   <= r_degen;
          end else begin
            r_drain <= r_drain - 2'd1;
          end
        end
        DONE: begin
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            r_state          <= IDLE;
            query_ready_out  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polygon_hit_tester.sv
// Self-checking bench for polygon_hit_tester: directed vector table, timing and
// reset sequences, and random polygons checked against a crossing-count model.
module tb_polygon_hit_tester;

  logic               clk_in = 1'b0;
  logic               rst_n_in;
  logic               query_valid_in;
  logic               query_ready_out;
  logic signed [31:0] x_in, y_in;
  logic [9:0]         base_in;
  logic [10:0]        count_in;
  logic               vert_rd_out;
  logic [9:0]         vert_addr_out;
  logic signed [31:0] vert_x_in, vert_y_in;
  logic               result_valid_out;
  logic               result_ready_in;
  logic               inside_out;
  logic [10:0]        crossings_out;
  logic               degenerate_out;

  polygon_hit_tester #(.WORLD_BITS(32), .ADDR_BITS(10), .MAX_VERTS(1024)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .query_valid_in(query_valid_in), .query_ready_out(query_ready_out),
    .x_in(x_in), .y_in(y_in), .base_in(base_in), .count_in(count_in),
    .vert_rd_out(vert_rd_out), .vert_addr_out(vert_addr_out),
    .vert_x_in(vert_x_in), .vert_y_in(vert_y_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .inside_out(inside_out), .crossings_out(crossings_out),
    .degenerate_out(degenerate_out)
  );

  always #5 clk_in = ~clk_in;

  logic signed [31:0] mem_x [0:1023];
  logic signed [31:0] mem_y [0:1023];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM model: data valid one cycle after the strobe, garbage otherwise
  always @(posedge clk_in) begin
    if (vert_rd_out) begin
      vert_x_in <= mem_x[vert_addr_out];
      vert_y_in <= mem_y[vert_addr_out];
    end else begin
      vert_x_in <= $urandom;
      vert_y_in <= $urandom;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic set_vert(input int a, input int vx, input int vy);
    mem_x[a] = vx;
    mem_y[a] = vy;
  endtask

  function automatic int ref_cross(input int b, input int c,
                                   input logic signed [31:0] px,
                                   input logic signed [31:0] py);
    int n;
    int ia, ib;
    logic signed [67:0] hx, hy, lx, ly, x68, y68, d;
    n = 0;
    x68 = px;
    y68 = py;
    for (int k = 0; k < c; k++) begin
      ia = (b + k) % 1024;
      ib = (b + (k + 1) % c) % 1024;
      if (mem_y[ia] > mem_y[ib]) begin
        hx = mem_x[ia]; hy = mem_y[ia]; lx = mem_x[ib]; ly = mem_y[ib];
      end else begin
        hx = mem_x[ib]; hy = mem_y[ib]; lx = mem_x[ia]; ly = mem_y[ia];
      end
      if (hy > y68 && y68 >= ly) begin
        d = (lx - hx) * (y68 - hy) - (ly - hy) * (x68 - hx);
        if (d <= 0) n++;
      end
    end
    return n;
  endfunction

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk_in);
    while (query_ready_out !== 1'b1 && w < 200) begin
      @(negedge clk_in);
      w++;
    end
  endtask

  task automatic run_query(input logic signed [31:0] qx, input logic signed [31:0] qy,
                           input int qb, input int qc, input int hold,
                           output logic o_ins, output int o_cr, output logic o_dg,
                           output int o_lat, output bit o_rd_ok, output bit o_hs_ok);
    bit         exp_rd;
    logic [9:0] exp_a;
    o_lat = -1; o_rd_ok = 1'b1; o_hs_ok = 1'b1;
    o_ins = 1'b0; o_cr = 0; o_dg = 1'b0;
    wait_ready();
    query_valid_in = 1'b1;
    x_in = qx; y_in = qy;
    base_in = 10'(qb); count_in = 11'(qc);
    @(posedge clk_in);
    #1;
    query_valid_in = 1'b0;
    x_in = $urandom; y_in = $urandom;
    base_in = 10'($urandom); count_in = 11'($urandom);
    for (int n = 1; n < qc + 60; n++) begin
      @(negedge clk_in);
      exp_rd = (qc >= 3) && (n <= qc + 1);
      if (vert_rd_out !== exp_rd) o_rd_ok = 1'b0;
      if (exp_rd) begin
        exp_a = (n - 1 == qc) ? 10'(qb) : 10'(qb + n - 1);
        if (vert_addr_out !== exp_a) o_rd_ok = 1'b0;
      end
      if (result_valid_out === 1'b1) begin
        o_lat = n;
        break;
      end
      @(posedge clk_in);
    end
    if (o_lat < 0) return;
    o_ins = inside_out; o_cr = int'(crossings_out); o_dg = degenerate_out;
    repeat (hold) begin
      @(negedge clk_in);
      if (result_valid_out !== 1'b1 || inside_out !== o_ins ||
          crossings_out !== 11'(o_cr) || degenerate_out !== o_dg ||
          query_ready_out !== 1'b0) o_hs_ok = 1'b0;
    end
    result_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    result_ready_in = 1'b0;
    @(negedge clk_in);
    if (result_valid_out !== 1'b0 || query_ready_out !== 1'b1) o_hs_ok = 1'b0;
  endtask

  typedef struct {
    string nm;
    int    x, y, base, cnt;
    int    ins, cr, dg, lat;
  } vec_t;

  task automatic do_vec(input vec_t v, input int hold);
    logic ins, dg;
    int   cr, lat;
    bit   rd_ok, hs_ok;
    run_query(v.x, v.y, v.base, v.cnt, hold, ins, cr, dg, lat, rd_ok, hs_ok);
    chk({v.nm, "_inside"}, ins, v.ins);
    chk({v.nm, "_cross"}, cr, v.cr);
    chk({v.nm, "_degen"}, dg, v.dg);
    chk({v.nm, "_latency"}, lat, v.lat);
    chk({v.nm, "_rdseq"}, rd_ok, 1);
    chk({v.nm, "_handshake"}, hs_ok, 1);
  endtask

  vec_t tbl [11];

  initial begin
    logic ins, dg;
    int   cr, lat, rc, rb, exp_c;
    bit   rd_ok, hs_ok, big;
    logic signed [31:0] px, py;
    int   acc [$];

    tbl[0]  = '{"sq_in",      50,  50,  0, 4, 1, 1, 0, 10};
    tbl[1]  = '{"sq_right",  150,  50,  0, 4, 0, 0, 0, 10};
    tbl[2]  = '{"sq_left",   -10,  50,  0, 4, 0, 2, 0, 10};
    tbl[3]  = '{"u_gap",      15,  50, 16, 8, 0, 2, 0, 14};
    tbl[4]  = '{"u_arm",       5,  50, 16, 8, 1, 3, 0, 14};
    tbl[5]  = '{"degen2",     50,  50,  0, 2, 0, 0, 1,  2};
    tbl[6]  = '{"degen0",      5,   5,  0, 0, 0, 0, 1,  2};
    tbl[7]  = '{"tri_in",     80,  50,  0, 3, 1, 1, 0,  9};
    tbl[8]  = '{"tri_out",    20,  50,  0, 3, 0, 2, 0,  9};
    tbl[9]  = '{"sq_bottom",  50,   0,  0, 4, 1, 1, 0, 10};
    tbl[10] = '{"sq_top",     50, 100,  0, 4, 0, 0, 0, 10};

    rst_n_in = 1'b0; query_valid_in = 1'b0; result_ready_in = 1'b0;
    x_in = '0; y_in = '0; base_in = '0; count_in = '0;
    for (int i = 0; i < 1024; i++) set_vert(i, 0, 0);
    set_vert(0, 0, 0);    set_vert(1, 100, 0);
    set_vert(2, 100, 100); set_vert(3, 0, 100);
    set_vert(16, 0, 0);   set_vert(17, 30, 0);  set_vert(18, 30, 100);
    set_vert(19, 20, 100); set_vert(20, 20, 10); set_vert(21, 10, 10);
    set_vert(22, 10, 100); set_vert(23, 0, 100);

    repeat (3) @(negedge clk_in);
    chk("reset_qready", query_ready_out, 0);
    chk("reset_valid", result_valid_out, 0);
    chk("reset_rd", vert_rd_out, 0);
    rst_n_in = 1'b1;

    for (int i = 0; i < 11; i++) do_vec(tbl[i], 0);

    // back-to-back throughput with the consumer always ready
    result_ready_in = 1'b1;
    wait_ready();
    query_valid_in = 1'b1; x_in = 50; y_in = 50; base_in = 0; count_in = 4;
    for (int i = 0; i < 60 && acc.size() < 2; i++) begin
      if (i > 0) @(negedge clk_in);
      if (query_ready_out === 1'b1) acc.push_back(cyc);
      @(posedge clk_in);
    end
    #1;
    query_valid_in = 1'b0;
    repeat (20) @(negedge clk_in);
    result_ready_in = 1'b0;
    chk("throughput", (acc.size() == 2) ? acc[1] - acc[0] : -1, 11);

    // random polygons against the model
    for (int it = 0; it < 30; it++) begin
      rc = $urandom_range(3, 12);
      rb = $urandom_range(0, 1023);
      big = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < rc; k++) begin
        if (big) set_vert((rb + k) % 1024, $urandom, $urandom);
        else set_vert((rb + k) % 1024, $urandom_range(0, 100) - 50, $urandom_range(0, 100) - 50);
      end
      if (big) begin
        px = $urandom; py = $urandom;
      end else begin
        px = $urandom_range(0, 100) - 50; py = $urandom_range(0, 100) - 50;
      end
      exp_c = ref_cross(rb, rc, px, py);
      run_query(px, py, rb, rc, 0, ins, cr, dg, lat, rd_ok, hs_ok);
      chk("rand_cross", cr, exp_c);
      chk("rand_inside", ins, exp_c % 2);
      chk("rand_latency", lat, rc + 6);
      chk("rand_rdseq", rd_ok, 1);
    end

    // address wrap plus long back-pressure
    set_vert(1022, 0, 0); set_vert(1023, 100, 0);
    set_vert(0, 100, 100); set_vert(1, 0, 100);
    do_vec('{"wrap_hold", 50, 50, 1022, 4, 1, 1, 0, 10}, 20);

    // reset in cycle 5 of a count-8 query
    wait_ready();
    query_valid_in = 1'b1; x_in = 15; y_in = 50; base_in = 16; count_in = 8;
    @(posedge clk_in);
    #1;
    query_valid_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #2;
    chk("pre_rst_rd", vert_rd_out, 1);
    rst_n_in = 1'b0;
    #1;
    chk("rst_rd", vert_rd_out, 0);
    chk("rst_addr", vert_addr_out, 0);
    chk("rst_qready", query_ready_out, 0);
    chk("rst_valid", result_valid_out, 0);
    chk("rst_outs", {inside_out, crossings_out, degenerate_out}, 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    do_vec('{"post_rst", 5, 50, 16, 8, 1, 3, 0, 14}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
